booth_iter_mul: RTL and testbench

BOOTH_ITER_MUL -- requirements
Module: booth_iter_mul

---
 rtl/booth_iter_mul.sv | 132 +++++++++++++
 tb/tb_booth_iter_mul.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_iter_mul.sv
// booth_iter_mul: iterative radix-4 Booth multiplier, 32x32 -> 64.
// Each BUSY cycle retires one Booth digit of the multiplier, so 17 digits
// cover both signed and unsigned operands. The request and result sides
// use valid/ready handshakes, and cancel aborts any operation.
// Optional build macro BOOTH_EARLY_TERM_EN: leave BUSY as soon as the
// remaining multiplier bits are all-0 or all-1, because every remaining
// digit is then zero. The product is the same with or without the macro.
module booth_iter_mul (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_signed,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        cancel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [63:0] a_reg;      // multiplicand, shifted left by 2 each iteration
    logic [34:0] b_reg;      // multiplier with a guard bit, shifted right by 2
    logic [63:0] acc_reg;    // running partial product
    logic [4:0]  cnt_reg;    // index of the current iteration

    logic        accept;
    logic        b_trivial;
    logic        iter_en;
    logic        term_neg;
    logic [63:0] term_mag;
    logic [63:0] term;
    logic [63:0] acc_next;
    logic        src1_ext;
    logic        src2_ext;

    assign accept   = in_valid & (state_reg == IDLE) & ~cancel;
    assign src1_ext = in_signed & src1[31];
    assign src2_ext = in_signed & src2[31];

`ifdef BOOTH_EARLY_TERM_EN
    assign b_trivial = (b_reg == '0) || (b_reg == '1);
`else
    assign b_trivial = 1'b0;
`endif

    // Add one Booth digit and shift only in a BUSY cycle that is not cut short.
    assign iter_en = (state_reg == BUSY) & ~cancel & ~b_trivial;

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Cancel overrides everything, including a request in IDLE.
    always_comb begin
        state_next = state_reg;
        if (cancel) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) state_next = BUSY;
                BUSY: begin
                    if (b_trivial || cnt_reg == 5'd16) begin
                        state_next = DONE;
                    end
                end
                DONE: if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Booth recoding of the low multiplier triplet. A negative term is
    // the inverted magnitude plus a carry-in of 1.
    always_comb begin
        term_mag = '0;
        term_neg = 1'b0;
        case (b_reg[2:0])
            3'b001, 3'b010: term_mag = a_reg;
            3'b011:         term_mag = a_reg << 1;
            3'b100: begin
                term_mag = a_reg << 1;
                term_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                term_mag = a_reg;
                term_neg = 1'b1;
            end
            default: term_mag = '0;
        endcase
        term     = term_neg ? ~term_mag : term_mag;
        acc_next = acc_reg + term + {63'd0, term_neg};
    end

    // Datapath: load the operands on accept, then run one Booth iteration per BUSY cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            a_reg   <= {{32{src1_ext}}, src1};
            b_reg   <= {src2_ext, src2_ext, src2, 1'b0};
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (iter_en) begin
            acc_reg <= acc_next;
            a_reg   <= a_reg << 2;
            b_reg   <= {b_reg[34], b_reg[34], b_reg[34:2]};
            cnt_reg <= cnt_reg + 5'd1;
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign out_result = acc_reg;

endmodule

// File: tb/tb_booth_iter_mul.sv
// Directed bench for booth_iter_mul. Expected products go into a scoreboard
// queue when a request is driven and are popped when out_valid rises.
module tb_booth_iter_mul;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_signed = 1'b0;
    logic        cancel = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_result;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    booth_iter_mul dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .src1      (src1),
        .src2      (src2),
        .cancel    (cancel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference product: extend both operands to 64 bits and multiply modulo 2^64.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // Clock edges from the accept edge to the first out_valid cycle.
    function automatic int exp_lat(input logic sgn, input logic [31:0] b);
        logic [34:0] bb;
        int          lat;
        lat = 17;
        bb  = {sgn & b[31], sgn & b[31], b, 1'b0};
        for (int i = 0; i < 17; i++) begin
            if ((bb == '0 || bb == '1) && lat == 17) lat = 1 + i;
            bb = {bb[34], bb[34], bb[34:2]};
        end
`ifdef BOOTH_EARLY_TERM_EN
        return lat;
`else
        return (lat > 0) ? 17 : 17;
`endif
    endfunction

    // One full request: accept, check latency and product, hold the result, then drain.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv, input int hold, input string tag);
        int          n;
        logic [63:0] want;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid  = 1'b1;
        in_signed = sgn;
        src1      = a;
        src2      = b;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        // Scramble the inputs while the operation is in flight.
        in_signed = ~sgn;
        src1      = $urandom;
        src2      = $urandom;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_lat(sgn, b)));
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        chk({tag, " result"}, out_result, want);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold valid"}, {63'd0, out_valid}, 64'd1);
            chk({tag, " hold result"}, out_result, want);
            chk({tag, " hold in_ready"}, {63'd0, in_ready}, 64'd0);
        end
        // in_valid is still high on the draining edge and must not be accepted.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, " drained in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, " drained out_valid"}, {63'd0, out_valid}, 64'd0);
        $display("op %s sgn=%0d a=%h b=%h lat=%0d result=%h", tag, sgn, a, b, n, want);
    endtask

    // Count out_valid pulses over a window where none are allowed.
    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin : stim
        int n;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset out_result", out_result, 64'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Corner products
        run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 0, "s_m1xm1");
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 0, "u_maxxmax");
        run_op(1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 0, "s_minxmin");
        run_op(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF80000001, 0, "s_maxxm1");
        run_op(1'b0, 32'h12345678, 32'h00000000, 64'h0, 0, "u_zero");
        run_op(1'b1, 32'h87654321, 32'h00000000, 64'h0, 0, "s_zero");
        run_op(1'b0, 32'hDEADBEEF, 32'h80000000, model(1'b0, 32'hDEADBEEF, 32'h80000000), 0, "u_top");

        // Hold the result for 5 cycles with out_ready low
        run_op(1'b1, 32'hCAFEF00D, 32'h13579BDF, model(1'b1, 32'hCAFEF00D, 32'h13579BDF), 5, "hold5");

        // Cancel wins over a request in IDLE
        in_valid = 1'b1;
        cancel   = 1'b1;
        src1     = 32'd7;
        src2     = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cancel   = 1'b0;
        chk("cancel idle in_ready", {63'd0, in_ready}, 64'd1);
        expect_quiet("cancel idle quiet", 20);
        $display("op cancel_in_idle");

        // Cancel at BUSY iteration 8
        in_valid  = 1'b1;
        in_signed = 1'b0;
        src1      = 32'h12345678;
        src2      = 32'h7654321F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("cancel busy pre in_ready", {63'd0, in_ready}, 64'd0);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel busy in_ready", {63'd0, in_ready}, 64'd1);
        chk("cancel busy out_valid", {63'd0, out_valid}, 64'd0);
        expect_quiet("cancel busy quiet", 20);
        $display("op cancel_in_busy");
        run_op(1'b0, 32'd3, 32'd5, 64'h000000000000000F, 0, "u_3x5");

        // Cancel in DONE discards the result
        in_valid  = 1'b1;
        in_signed = 1'b1;
        src1      = 32'd11;
        src2      = 32'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cancel done reached", {63'd0, out_valid}, 64'd1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel done out_valid", {63'd0, out_valid}, 64'd0);
        chk("cancel done in_ready", {63'd0, in_ready}, 64'd1);
        $display("op cancel_in_done");

        // Asynchronous reset mid-BUSY
        in_valid  = 1'b1;
        in_signed = 1'b1;
        src1      = 32'hA5A5A5A5;
        src2      = 32'h5A5A5A5A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("async reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("async reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("async reset out_result", out_result, 64'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        expect_quiet("async reset quiet", 25);
        $display("op async_reset_mid_busy");

        // Random vectors against the reference model
        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (i == 3) rb = 32'h0000000F;
            if (i == 5) rb = 32'hFFFFFFF0;
            run_op(rs, ra, rb, model(rs, ra, rb), (i % 4 == 0) ? 2 : 0, "rand");
        end

        chk("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
